// File: rtl/mos6502s_indirect_fetch_ctrl.sv
// Resolves 6502 indirect, (zp,X) and (zp),Y effective addresses
// by fetching the two pointer bytes over a stallable read port.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_start, i_mode         request and addressing mode (9/A/B)
//   i_operand_lo/hi         instruction operand bytes
//   i_x_reg, i_y_reg        index registers
//   o_mem_addr, o_mem_rd    read request to memory
//   i_mem_rdata, i_mem_ready read data and completion
//   o_busy, o_done          status; done is a one-cycle pulse
//   o_eff_addr, o_page_cross, o_error  result, valid with done
module mos6502s_indirect_fetch_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_mode,
  input  logic [7:0]  i_operand_lo,
  input  logic [7:0]  i_operand_hi,
  input  logic [7:0]  i_x_reg,
  input  logic [7:0]  i_y_reg,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_eff_addr,
  output logic        o_page_cross,
  output logic        o_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_mode;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [7:0]  r_ptr_l;
  logic [15:0] r_eff;
  logic        r_pc;
  logic        r_err;

  logic        w_mode_ok;
  logic [7:0]  w_zp;
  logic [15:0] w_lo_ptr;
  logic [15:0] w_hi_ptr;
  logic [15:0] w_base;
  logic [15:0] w_eff_b;
  logic [8:0]  w_lsum;

  assign w_mode_ok = (i_mode == 4'h9) ||
                     (i_mode == 4'hA) ||
                     (i_mode == 4'hB);

  assign w_zp    = r_lo + r_x;
  assign w_base  = {i_mem_rdata, r_ptr_l};
  assign w_eff_b = w_base + {8'h00, r_y};
  assign w_lsum  = {1'b0, r_ptr_l} + {1'b0, r_y};

  // Pointer high byte never carries into the page byte:
  // the 6502 wraps within the page (mode 9) or zero page.
  always_comb begin
    w_lo_ptr = 16'h0000;
    w_hi_ptr = 16'h0000;
    unique case (1'b1)
      (r_mode == 4'h9): begin
        w_lo_ptr = {r_hi, r_lo};
        w_hi_ptr = {r_hi, r_lo + 8'd1};
      end
      (r_mode == 4'hA): begin
        w_lo_ptr = {8'h00, w_zp};
        w_hi_ptr = {8'h00, w_zp + 8'd1};
      end
      default: begin
        w_lo_ptr = {8'h00, r_lo};
        w_hi_ptr = {8'h00, r_lo + 8'd1};
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_mem_rd   = 1'b0;
    o_mem_addr = 16'h0000;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start)
          w_next = w_mode_ok ? S_LO : S_DONE;
      end
      S_LO: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_lo_ptr;
        if (i_mem_ready) w_next = S_HI;
      end
      S_HI: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_hi_ptr;
        if (i_mem_ready) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode  <= 4'h0;
      r_lo    <= 8'h00;
      r_hi    <= 8'h00;
      r_x     <= 8'h00;
      r_y     <= 8'h00;
      r_ptr_l <= 8'h00;
      r_eff   <= 16'h0000;
      r_pc    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode <= i_mode;
            r_lo   <= i_operand_lo;
            r_hi   <= i_operand_hi;
            r_x    <= i_x_reg;
            r_y    <= i_y_reg;
            if (!w_mode_ok) begin
              r_eff <= 16'h0000;
              r_pc  <= 1'b0;
              r_err <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (i_mem_ready) r_ptr_l <= i_mem_rdata;
        end
        S_HI: begin
          if (i_mem_ready) begin
            r_err <= 1'b0;
            if (r_mode == 4'hB) begin
              r_eff <= w_eff_b;
              r_pc  <= w_lsum[8];
            end else begin
              r_eff <= w_base;
              r_pc  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_eff_addr   = r_eff;
  assign o_page_cross = r_pc;
  assign o_error      = r_err;

endmodule

// File: doc/mos6502s_indirect_fetch_ctrl.md
MOS6502S_INDIRECT_FETCH_CTRL -- requirements
Module: mos6502s_indirect_fetch_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a pointer fetch; sampled in IDLE only.
REQ-005 mode  input  4  addressing mode: 4'h9 indirect, 4'hA indexed-indirect (zp,X), 4'hB indirect-indexed (zp),Y; any other value is invalid.
REQ-006 operand_lo / operand_hi  input  8 each  instruction operand bytes.
REQ-007 x_reg / y_reg  input  8 each  index registers.
REQ-008 mem_addr  output  16  read address presented to memory.
REQ-009 mem_rd  output  1  read strobe; mem_addr is valid whenever mem_rd=1.
REQ-010 mem_rdata  input  8  read data; valid in the cycle mem_ready=1.
REQ-011 mem_ready  input  1  completes the current read when high with mem_rd=1; may stall indefinitely.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; eff_addr, page_cross and error are valid while it is high.
REQ-014 eff_addr  output  16  resolved effective address.
REQ-015 page_cross  output  1  Y addition carried out of the low byte (mode B only).
REQ-016 error  output  1  the request carried an invalid mode.

Function
REQ-017 States: IDLE, FETCH_LO, FETCH_HI, DONE; 2-bit encoding; no other reachable state.
REQ-018 In IDLE, start=1 latches mode, operand_lo, operand_hi, x_reg and y_reg; later input changes have no effect until the next IDLE.
REQ-019 IDLE + start + valid mode -> FETCH_LO on the next edge.
REQ-020 IDLE + start + invalid mode -> DONE with error=1, eff_addr=16'h0000 and page_cross=0; no memory read is issued.
REQ-021 Pointer addresses: mode 9: lo={hi,lo}; hi=({hi,8'h00} if lo==8'hFF, else {hi,lo}+1).
REQ-022 Mode A: zp=(lo+x) mod 256; lo ptr={8'h00,zp}; hi ptr={8'h00,(zp+1) mod 256}.
REQ-023 Mode B: lo ptr={8'h00,lo}; hi ptr={8'h00,(lo+1) mod 256}.
REQ-024 FETCH_LO: mem_rd=1 and mem_addr=lo ptr.
  - When mem_ready=1, latch mem_rdata as ptr byte L and go to FETCH_HI.
  - Otherwise hold the state and mem_addr unchanged.
REQ-025 FETCH_HI: mem_rd=1 and mem_addr=hi ptr.
  - When mem_ready=1, latch mem_rdata as byte H, register eff_addr and page_cross, and go to DONE.
  - Otherwise hold.
REQ-026 eff_addr: modes 9 and A = {H,L}; mode B = ({H,L}+{8'h00,y}) mod 65536.
REQ-027 page_cross = carry out of (L+y) in mode B; 0 in modes 9 and A.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
  - start during DONE is ignored.
  - eff_addr, page_cross and error hold their values until the next DONE.
REQ-029 mem_rd=0 and mem_addr=16'h0000 in IDLE and DONE.
REQ-030 start asserted while busy=1 is ignored; it is not queued.
REQ-031 Best-case latency with mem_ready held high: start sampled at edge N -> done high in cycle N+3. Each stall cycle on a read adds one cycle.
REQ-032 error is cleared on every valid-mode completion.

Reset
REQ-033 rst=1 forces the following immediately, regardless of clk, including mid-fetch: state=IDLE, mem_rd=0, mem_addr=0, busy=0, done=0, eff_addr=0, page_cross=0, error=0, and all latched operands and pointer bytes = 0.
REQ-034 A read in progress when reset asserts is abandoned. The first start after rst deasserts begins a fresh sequence.

Verification
REQ-035 Mode 9 page-wrap: operand=12FF, memory[12FF]=34, memory[1200]=56, ready always high -> reads 12FF then 1200; eff_addr=5634 at cycle N+3; page_cross=0.
REQ-036 Mode A zero-page wrap: operand_lo=FE, x=01, memory[00FF]=00, memory[0000]=80 -> reads 00FF then 0000; eff_addr=8000.
REQ-037 Mode B with page cross: operand_lo=40, y=10, memory[0040]=F8, memory[0041]=20 -> eff_addr=2108, page_cross=1. Also: y=10 with L=F0, H=FF -> eff_addr=0000, page_cross=1 (16-bit wrap).
REQ-038 Stall and ignored start: ready low for 3 cycles in FETCH_LO with start pulsed during the stall -> mem_addr stable throughout; done appears at cycle N+6; exactly one done pulse.
REQ-039 Invalid mode 4'h3 -> no mem_rd; done and error high at cycle N+1; next valid request clears error.
REQ-040 Reset mid-fetch: rst asserted in FETCH_HI -> mem_rd and busy fall without a clock edge; no done pulse; a subsequent request completes normally.
